// File: rtl/render_frame_scheduler.sv
// Frame-synchronous control for the renderer: scroll offsets, bird animation and pause dimming
// all change once per frame at the start of vertical blank, so nothing moves mid-frame.
module render_frame_scheduler #(
  parameter int unsigned DISPLAY_SIZE_X = 640,
  parameter int unsigned DISPLAY_SIZE_Y = 480,
  parameter int unsigned BG_STEP        = 1,
  parameter int unsigned FL_STEP        = 2,
  parameter int unsigned FLAP_PERIOD    = 6,
  parameter int unsigned FADE_FRAMES    = 4
) (
  input  logic        VGA_clk,
  input  logic        rst,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic [3:0]  game_state,
  input  logic        flap,
  output logic        frame_tick,
  output logic [15:0] bg_ofs,
  output logic [15:0] fl_ofs,
  output logic [2:0]  bird_state,
  output logic [1:0]  dim_level,
  output logic [15:0] frame_count
);

  localparam logic [3:0] GS_START = 4'b0001;
  localparam logic [3:0] GS_GAME  = 4'b0010;
  localparam logic [3:0] GS_PAUSE = 4'b0100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLAP1 = 2'd1;
  localparam logic [1:0] ST_FLAP2 = 2'd2;
  localparam logic [1:0] ST_FLAP3 = 2'd3;

  logic        r_vb_q, r_tick, r_flap_pending;
  logic [15:0] r_bg, r_fl, r_hold, r_fade, r_frame_count;
  logic [2:0]  r_bird;
  logic [1:0]  r_state, r_dim;

  logic        w_vb, w_start, w_in_game, w_paused, w_scroll, w_flap_any, w_hold_done;
  logic [16:0] w_bg_sum, w_fl_sum;
  logic [15:0] w_bg_d, w_fl_d, w_hold_d, w_fade_d;
  logic [2:0]  w_bird_d;
  logic [1:0]  w_state_d, w_dim_d, w_dim_tgt;
  logic        w_unused_x;

  assign w_unused_x  = ^X;
  assign w_vb        = (Y >= 16'(DISPLAY_SIZE_Y));
  assign w_start     = (game_state == GS_START);
  assign w_in_game   = (game_state == GS_GAME);
  assign w_paused    = (game_state == GS_PAUSE);
  assign w_scroll    = w_start | w_in_game;
  // A flap arriving in the tick cycle still counts for that tick.
  assign w_flap_any  = r_flap_pending | flap;
  assign w_hold_done = (r_hold == 16'(FLAP_PERIOD - 1));

  assign w_bg_sum = {1'b0, r_bg} + 17'(BG_STEP);
  assign w_fl_sum = {1'b0, r_fl} + 17'(FL_STEP);
  assign w_bg_d   = (w_bg_sum >= 17'(DISPLAY_SIZE_X)) ? 16'(w_bg_sum - 17'(DISPLAY_SIZE_X))
                                                       : w_bg_sum[15:0];
  assign w_fl_d   = (w_fl_sum >= 17'(DISPLAY_SIZE_X)) ? 16'(w_fl_sum - 17'(DISPLAY_SIZE_X))
                                                       : w_fl_sum[15:0];

  always_comb begin
    w_state_d = r_state;
    w_hold_d  = r_hold;
    w_bird_d  = r_bird;
    if (w_in_game && w_flap_any) begin
      w_state_d = ST_FLAP1;
      w_bird_d  = 3'd1;
      w_hold_d  = '0;
    end else if (r_state != ST_IDLE) begin
      if (w_in_game) begin
        if (w_hold_done) begin
          w_hold_d = '0;
          unique case (r_state)
            ST_FLAP1: begin w_state_d = ST_FLAP2; w_bird_d = 3'd2; end
            ST_FLAP2: begin w_state_d = ST_FLAP3; w_bird_d = 3'd1; end
            default:  begin w_state_d = ST_IDLE;  w_bird_d = 3'd0; end
          endcase
        end else begin
          w_hold_d = r_hold + 16'd1;
        end
      end else if (!w_paused) begin
        // START, END or an invalid encoding abandons the flap sequence.
        w_state_d = ST_IDLE;
        w_hold_d  = '0;
      end
    end else if (w_start) begin
      if (w_hold_done) begin
        w_hold_d = '0;
        w_bird_d = (r_bird == 3'd2) ? 3'd0 : r_bird + 3'd1;
      end else begin
        w_hold_d = r_hold + 16'd1;
      end
    end else if (w_in_game) begin
      w_bird_d = 3'd0;
      w_hold_d = '0;
    end
  end

  always_comb begin
    w_dim_tgt = w_paused ? 2'd3 : 2'd0;
    w_dim_d   = r_dim;
    w_fade_d  = r_fade;
    if (r_dim == w_dim_tgt) begin
      w_fade_d = '0;
    end else if (r_fade == 16'(FADE_FRAMES - 1)) begin
      w_fade_d = '0;
      w_dim_d  = (w_dim_tgt > r_dim) ? r_dim + 2'd1 : r_dim - 2'd1;
    end else begin
      w_fade_d = r_fade + 16'd1;
    end
  end

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      r_vb_q         <= 1'b0;
      r_tick         <= 1'b0;
      r_flap_pending <= 1'b0;
      r_bg           <= '0;
      r_fl           <= '0;
      r_hold         <= '0;
      r_fade         <= '0;
      r_frame_count  <= '0;
      r_bird         <= '0;
      r_state        <= ST_IDLE;
      r_dim          <= '0;
    end else begin
      r_vb_q         <= w_vb;
      r_tick         <= w_vb & ~r_vb_q;
      r_flap_pending <= r_tick ? 1'b0 : w_flap_any;
      if (r_tick) begin
        r_frame_count <= r_frame_count + 16'd1;
        if (w_scroll) begin
          r_bg <= w_bg_d;
          r_fl <= w_fl_d;
        end
        r_state <= w_state_d;
        r_hold  <= w_hold_d;
        r_bird  <= w_bird_d;
        r_dim   <= w_dim_d;
        r_fade  <= w_fade_d;
      end
    end
  end

  assign frame_tick  = r_tick;
  assign bg_ofs      = r_bg;
  assign fl_ofs      = r_fl;
  assign bird_state  = r_bird;
  assign dim_level   = r_dim;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Bench for render_frame_scheduler: scripted frame table, timing/reset corner cases and a
// randomized run against a per-cycle behavioural model.
module tb_render_frame_scheduler;

  localparam int unsigned DX = 640;
  localparam int unsigned DY = 480;
  localparam int unsigned BG = 1;
  localparam int unsigned FL = 2;
  localparam int unsigned FP = 6;
  localparam int unsigned FF = 4;
  localparam logic [3:0] G_START = 4'b0001;
  localparam logic [3:0] G_GAME  = 4'b0010;
  localparam logic [3:0] G_PAUSE = 4'b0100;
  localparam logic [3:0] G_END   = 4'b1000;

  logic        VGA_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] X = '0;
  logic [15:0] Y = '0;
  logic [3:0]  game_state = G_START;
  logic        flap = 1'b0;
  logic        frame_tick;
  logic [15:0] bg_ofs, fl_ofs, frame_count;
  logic [2:0]  bird_state;
  logic [1:0]  dim_level;

  render_frame_scheduler #(
    .DISPLAY_SIZE_X(DX), .DISPLAY_SIZE_Y(DY), .BG_STEP(BG), .FL_STEP(FL),
    .FLAP_PERIOD(FP), .FADE_FRAMES(FF)
  ) dut (
    .VGA_clk(VGA_clk), .rst(rst), .X(X), .Y(Y), .game_state(game_state), .flap(flap),
    .frame_tick(frame_tick), .bg_ofs(bg_ofs), .fl_ofs(fl_ofs), .bird_state(bird_state),
    .dim_level(dim_level), .frame_count(frame_count)
  );

  always #5 VGA_clk = ~VGA_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: flap progress is tracked as ticks elapsed since the flap was taken.
  int m_vbq, m_tick, m_pend, m_bg, m_fl, m_bird, m_dim, m_fc;
  int m_flapping, m_age, m_hold, m_fade;
  int seq_v[3] = '{1, 2, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vbq = 0; m_tick = 0; m_pend = 0; m_bg = 0; m_fl = 0; m_bird = 0; m_dim = 0; m_fc = 0;
    m_flapping = 0; m_age = 0; m_hold = 0; m_fade = 0;
  endtask

  task automatic model_tick(input logic [3:0] gs, input bit f);
    bit took, ing, pse, st;
    int tgt;
    took = (m_pend != 0) || f;
    m_pend = 0;
    ing = (gs == G_GAME); pse = (gs == G_PAUSE); st = (gs == G_START);
    m_fc = (m_fc + 1) % 65536;
    if (st || ing) begin
      m_bg = (m_bg + BG) % DX;
      m_fl = (m_fl + FL) % DX;
    end
    if (ing && took) begin
      m_flapping = 1; m_age = 0; m_bird = 1;
    end else if (m_flapping != 0) begin
      if (ing) begin
        m_age++;
        if (m_age >= 3 * FP) begin m_flapping = 0; m_bird = 0; m_hold = 0; end
        else m_bird = seq_v[m_age / FP];
      end else if (!pse) begin
        m_flapping = 0; m_hold = 0;
      end
    end else if (st) begin
      m_hold++;
      if (m_hold == FP) begin m_hold = 0; m_bird = (m_bird + 1) % 3; end
    end else if (ing) begin
      m_bird = 0; m_hold = 0;
    end
    tgt = pse ? 3 : 0;
    if (m_dim == tgt) m_fade = 0;
    else begin
      m_fade++;
      if (m_fade == FF) begin m_fade = 0; m_dim += (tgt > m_dim) ? 1 : -1; end
    end
  endtask

  // One clock: advance the model with the inputs now applied, clock the DUT, compare.
  task automatic cycle();
    int vb;
    vb = (Y >= DY) ? 1 : 0;
    if (m_tick != 0) model_tick(game_state, flap);
    else if (flap) m_pend = 1;
    m_tick = (vb != 0 && m_vbq == 0) ? 1 : 0;
    m_vbq = vb;
    @(posedge VGA_clk);
    #1;
    X = X + 16'd1;
    chk("model frame_tick", {31'd0, frame_tick}, m_tick);
    chk("model bg_ofs", {16'd0, bg_ofs}, m_bg);
    chk("model fl_ofs", {16'd0, fl_ofs}, m_fl);
    chk("model bird_state", {29'd0, bird_state}, m_bird);
    chk("model dim_level", {30'd0, dim_level}, m_dim);
    chk("model frame_count", {16'd0, frame_count}, m_fc);
  endtask

  task automatic do_reset();
    Y = '0; flap = 1'b0; rst = 1'b1;
    model_reset();
    repeat (2) @(posedge VGA_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] gs, input bit do_flap);
    game_state = gs;
    Y = 16'd100;
    for (int i = 0; i < 3; i++) begin
      flap = do_flap && (i == 1);
      cycle();
    end
    flap = 1'b0;
    Y = 16'(DY);
    repeat (3) cycle();
    Y = 16'd0;
    cycle();
  endtask

  typedef struct {
    logic [3:0] gs;
    int frames;
    bit fl;
    int bg, fo, bird, dim, fc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{G_GAME,  3,  1'b0, 3,  6,  0, 0, 3};
    tbl[1]  = '{G_GAME,  1,  1'b1, 4,  8,  1, 0, 4};
    tbl[2]  = '{G_GAME,  5,  1'b0, 9,  18, 1, 0, 9};
    tbl[3]  = '{G_GAME,  1,  1'b0, 10, 20, 2, 0, 10};
    tbl[4]  = '{G_GAME,  6,  1'b0, 16, 32, 1, 0, 16};
    tbl[5]  = '{G_GAME,  6,  1'b0, 22, 44, 0, 0, 22};
    tbl[6]  = '{G_PAUSE, 3,  1'b0, 22, 44, 0, 0, 25};
    tbl[7]  = '{G_PAUSE, 1,  1'b0, 22, 44, 0, 1, 26};
    tbl[8]  = '{G_PAUSE, 4,  1'b0, 22, 44, 0, 2, 30};
    tbl[9]  = '{G_GAME,  3,  1'b0, 25, 50, 0, 2, 33};
    tbl[10] = '{G_GAME,  1,  1'b0, 26, 52, 0, 1, 34};
    tbl[11] = '{G_GAME,  4,  1'b0, 30, 60, 0, 0, 38};
    tbl[12] = '{G_PAUSE, 12, 1'b0, 30, 60, 0, 3, 50};
    tbl[13] = '{G_START, 5,  1'b1, 35, 70, 0, 2, 55};
    tbl[14] = '{G_START, 1,  1'b0, 36, 72, 1, 2, 56};
    tbl[15] = '{G_START, 6,  1'b0, 42, 84, 2, 0, 62};
    tbl[16] = '{G_START, 6,  1'b0, 48, 96, 0, 0, 68};
    tbl[17] = '{G_GAME,  1,  1'b0, 49, 98, 0, 0, 69};

    // Reset values
    do_reset();
    chk("reset frame_tick", {31'd0, frame_tick}, 0);
    chk("reset bg_ofs", {16'd0, bg_ofs}, 0);
    chk("reset fl_ofs", {16'd0, fl_ofs}, 0);
    chk("reset bird_state", {29'd0, bird_state}, 0);
    chk("reset dim_level", {30'd0, dim_level}, 0);
    chk("reset frame_count", {16'd0, frame_count}, 0);

    // Scripted frame table
    for (int i = 0; i < 18; i++) begin
      for (int f = 0; f < tbl[i].frames; f++) run_frame(tbl[i].gs, tbl[i].fl && (f == 0));
      chk($sformatf("tbl%0d bg_ofs", i), {16'd0, bg_ofs}, tbl[i].bg);
      chk($sformatf("tbl%0d fl_ofs", i), {16'd0, fl_ofs}, tbl[i].fo);
      chk($sformatf("tbl%0d bird_state", i), {29'd0, bird_state}, tbl[i].bird);
      chk($sformatf("tbl%0d dim_level", i), {30'd0, dim_level}, tbl[i].dim);
      chk($sformatf("tbl%0d frame_count", i), {16'd0, frame_count}, tbl[i].fc);
    end

    // Tick timing: pulse one cycle after Y reaches DY, outputs one cycle later, single pulse
    do_reset();
    game_state = G_GAME;
    repeat (3) cycle();
    Y = 16'(DY);
    cycle();
    chk("timing tick high", {31'd0, frame_tick}, 1);
    chk("timing count before", {16'd0, frame_count}, 0);
    cycle();
    chk("timing tick low", {31'd0, frame_tick}, 0);
    chk("timing count after", {16'd0, frame_count}, 1);
    chk("timing bg after", {16'd0, bg_ofs}, 1);
    Y = 16'(DY + 20);
    repeat (3) cycle();
    chk("timing one pulse", {16'd0, frame_count}, 1);
    Y = 16'd0;
    cycle();

    // Offset wrap at DISPLAY_SIZE_X
    do_reset();
    for (int f = 0; f < 639; f++) run_frame(G_GAME, 1'b0);
    chk("wrap pre bg", {16'd0, bg_ofs}, 639);
    chk("wrap pre fl", {16'd0, fl_ofs}, 638);
    run_frame(G_GAME, 1'b0);
    chk("wrap bg", {16'd0, bg_ofs}, 0);
    chk("wrap fl", {16'd0, fl_ofs}, 0);
    run_frame(G_GAME, 1'b0);
    chk("wrap next bg", {16'd0, bg_ofs}, 1);
    chk("wrap next fl", {16'd0, fl_ofs}, 2);

    // Flap in the very cycle frame_tick is high counts for that tick
    do_reset();
    game_state = G_GAME;
    repeat (2) cycle();
    Y = 16'(DY);
    cycle();
    flap = 1'b1;
    cycle();
    flap = 1'b0;
    chk("same-cycle flap bird", {29'd0, bird_state}, 1);
    Y = 16'd0;
    cycle();

    // Asynchronous reset mid-frame
    do_reset();
    for (int f = 0; f < 50; f++) run_frame(G_GAME, 1'b0);
    chk("pre-reset bg", {16'd0, bg_ofs}, 50);
    Y = 16'd200;
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("async rst bg", {16'd0, bg_ofs}, 0);
    chk("async rst fl", {16'd0, fl_ofs}, 0);
    chk("async rst count", {16'd0, frame_count}, 0);
    model_reset();
    @(posedge VGA_clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle();
    chk("post rst no tick", {31'd0, frame_tick}, 0);
    Y = 16'(DY);
    cycle();
    chk("post rst tick", {31'd0, frame_tick}, 1);
    Y = 16'd0;
    cycle();

    // Randomized run against the model
    do_reset();
    for (int f = 0; f < 400; f++) begin
      int r, nv, nb;
      r = $urandom_range(0, 15);
      if (r < 3) game_state = G_START;
      else if (r < 9) game_state = G_GAME;
      else if (r < 13) game_state = G_PAUSE;
      else if (r < 14) game_state = G_END;
      else game_state = 4'($urandom_range(0, 15));
      nv = $urandom_range(1, 6);
      nb = $urandom_range(1, 4);
      for (int c = 0; c < nv + nb; c++) begin
        Y = (c < nv) ? 16'($urandom_range(0, DY - 1)) : 16'($urandom_range(DY, DY + 44));
        flap = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) game_state = G_GAME;
        cycle();
      end
      flap = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
